// File: rtl/variable_delay_line_mc.sv
// variable_delay_line_mc
//   Multi-channel sample-strobed delay line. All lanes share one write pointer
//   and one occupancy counter. Each lane has its own runtime delay tap.
//   Lane c output for accepted sample n is x_c[n - d_c], or DEFAULT_DATA when
//   that sample predates the stored history.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   clk_en          global enable; every register holds while low
//   flush           discard history (occupancy -> 0); contents are not cleared
//   data_in/stb_in  lane sample vector (lane c at [c*WIDTH +: WIDTH]) + strobe
//   delay           per-lane delay taps (lane c at [c*DW +: DW])
//   data_out        delayed samples, same packing; holds between strobes
//   stb_out         data_out updated (qualify with clk_en)
//   occupied        valid samples in history, saturates at DEPTH
//   delay_err       sticky: some accepted lane delay exceeded DEPTH-1
//
// Build option
//   VARIABLE_DELAY_LINE_MC_DELAY_CLAMP_EN  clamp out-of-range delays to DEPTH-1
//   instead of forcing DEFAULT_DATA on the offending lane.
module variable_delay_line_mc #(
    parameter int unsigned       WIDTH        = 18,
    parameter int unsigned       DEPTH        = 256,
    parameter int unsigned       NUM_CHAN     = 4,
    parameter logic [WIDTH-1:0]  DEFAULT_DATA = '0,
    parameter int unsigned       OUT_REG      = 0,
    localparam int unsigned      DW           = $clog2(DEPTH),
    localparam int unsigned      OW           = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clk_en,
    input  logic                      flush,
    input  logic [NUM_CHAN*WIDTH-1:0] data_in,
    input  logic                      stb_in,
    input  logic [NUM_CHAN*DW-1:0]    delay,
    output logic [NUM_CHAN*WIDTH-1:0] data_out,
    output logic                      stb_out,
    output logic [OW-1:0]             occupied,
    output logic                      delay_err
);

    localparam logic [DW-1:0] PTR_MAX = DW'(DEPTH - 1);
    localparam logic [DW-1:0] PTR_ONE = DW'(1);
    localparam logic [DW:0]   DEPTH_X = (DW + 1)'(DEPTH);
    localparam logic [OW-1:0] OCC_MAX = OW'(DEPTH);
    localparam logic [OW-1:0] OCC_ONE = OW'(1);

    logic          accept;
    logic [OW-1:0] occ_inc;
    logic [DW-1:0] wptr_q, wptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          err_q, err_d;
    logic          stb1_q, stb1_d;
    logic [NUM_CHAN-1:0] lane_oor;

    // occ_inc is the occupancy that includes the sample being accepted now;
    // a flush in the same cycle makes that sample the first one.
    always_comb begin
        accept  = clk_en & stb_in;
        occ_inc = flush ? OCC_ONE : ((occ_q == OCC_MAX) ? occ_q : occ_q + OCC_ONE);
        wptr_d  = wptr_q;
        occ_d   = occ_q;
        stb1_d  = stb1_q;
        err_d   = err_q | (accept & (|lane_oor));
        if (clk_en) begin
            stb1_d = accept;
            if (accept) begin
                wptr_d = (wptr_q == PTR_MAX) ? '0 : wptr_q + PTR_ONE;
                occ_d  = occ_inc;
            end else if (flush) begin
                occ_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            occ_q  <= '0;
            err_q  <= 1'b0;
            stb1_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            occ_q  <= occ_d;
            err_q  <= err_d;
            stb1_q <= stb1_d;
        end
    end

    assign occupied  = occ_q;
    assign delay_err = err_q;

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_lane
        logic [DW-1:0]    d_raw, d_eff, raddr;
        logic [WIDTH-1:0] din, lane_val;
        logic             oor, under;
        logic             def_q, def_d, sel_byp_q, sel_byp_d;
        logic [WIDTH-1:0] byp_q, byp_d, rd_q;
        logic [WIDTH-1:0] mem [DEPTH];

        assign d_raw = delay[c*DW +: DW];
        assign din   = data_in[c*WIDTH +: WIDTH];

        always_comb begin
            oor = ({1'b0, d_raw} > {1'b0, PTR_MAX});
`ifdef VARIABLE_DELAY_LINE_MC_DELAY_CLAMP_EN
            d_eff = oor ? PTR_MAX : d_raw;
            under = ({{(OW-DW){1'b0}}, d_eff} >= occ_inc);
`else
            // Out-of-range taps are forced to DEFAULT; address them at 0 so
            // the read never leaves the array.
            d_eff = oor ? '0 : d_raw;
            under = oor | ({{(OW-DW){1'b0}}, d_eff} >= occ_inc);
`endif
            // Explicit modulo so non-power-of-2 DEPTH never aliases.
            if (d_eff <= wptr_q) raddr = wptr_q - d_eff;
            else                 raddr = DW'({1'b0, wptr_q} + DEPTH_X - {1'b0, d_eff});

            def_d     = def_q;
            sel_byp_d = sel_byp_q;
            byp_d     = byp_q;
            if (accept) begin
                def_d     = under;
                // d=0 reads the slot being written this cycle; take data_in.
                sel_byp_d = (d_eff == '0);
                byp_d     = din;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                def_q     <= 1'b1;
                sel_byp_q <= 1'b0;
                byp_q     <= '0;
            end else begin
                def_q     <= def_d;
                sel_byp_q <= sel_byp_d;
                byp_q     <= byp_d;
            end
        end

        // Simple dual-port RAM with registered read; kept reset-free so it
        // maps onto block RAM.
        always_ff @(posedge clk) begin
            if (accept) begin
                mem[wptr_q] <= din;
                rd_q        <= mem[raddr];
            end
        end

        assign lane_val    = def_q ? DEFAULT_DATA : (sel_byp_q ? byp_q : rd_q);
        assign lane_oor[c] = oor;

        if (OUT_REG != 0) begin : g_oreg
            logic [WIDTH-1:0] out_q, out_d;
            always_comb out_d = (clk_en & stb1_q) ? lane_val : out_q;
            always_ff @(posedge clk) begin
                if (reset) out_q <= DEFAULT_DATA;
                else       out_q <= out_d;
            end
            assign data_out[c*WIDTH +: WIDTH] = out_q;
        end else begin : g_nreg
            assign data_out[c*WIDTH +: WIDTH] = lane_val;
        end
    end

    if (OUT_REG != 0) begin : g_stb_reg
        logic stb2_q, stb2_d;
        always_comb stb2_d = clk_en ? stb1_q : stb2_q;
        always_ff @(posedge clk) begin
            if (reset) stb2_q <= 1'b0;
            else       stb2_q <= stb2_d;
        end
        assign stb_out = stb2_q;
    end else begin : g_stb_nreg
        assign stb_out = stb1_q;
    end

endmodule

// File: tb/tb_variable_delay_line_mc.sv
// Self-checking bench for variable_delay_line_mc: two instances (OUT_REG=0/1)
// share the same stimulus, DEPTH=6 (non-power-of-2), four lanes.
module tb_variable_delay_line_mc;
    localparam int W  = 8;
    localparam int D  = 6;
    localparam int NC = 4;
    localparam int DW = $clog2(D);
    localparam int OW = $clog2(D + 1);
    localparam logic [W-1:0] DEF = 8'hA5;

    logic clk = 1'b0, reset = 1'b1, clk_en = 1'b0, flush = 1'b0, stb_in = 1'b0;
    logic [NC*W-1:0]  data_in = '0;
    logic [NC*DW-1:0] delay = '0;
    logic [NC*W-1:0]  dout0, dout1;
    logic stbo0, stbo1, err0, err1;
    logic [OW-1:0] occ0, occ1;

    always #5 clk = ~clk;

    variable_delay_line_mc #(.WIDTH(W), .DEPTH(D), .NUM_CHAN(NC), .DEFAULT_DATA(DEF), .OUT_REG(0)) u0 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .data_in(data_in),
        .stb_in(stb_in), .delay(delay), .data_out(dout0), .stb_out(stbo0),
        .occupied(occ0), .delay_err(err0));

    variable_delay_line_mc #(.WIDTH(W), .DEPTH(D), .NUM_CHAN(NC), .DEFAULT_DATA(DEF), .OUT_REG(1)) u1 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .data_in(data_in),
        .stb_in(stb_in), .delay(delay), .data_out(dout1), .stb_out(stbo1),
        .occupied(occ1), .delay_err(err1));

    int checks = 0, errors = 0;

    // reference model
    logic [NC*W-1:0] hist[$];
    logic [NC*W-1:0] sb[$];
    logic [NC*W-1:0] m_out0, m_out1;
    logic m_stb0, m_stb1, m_err;
    int   m_occ;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("stb0", 64'(stbo0), 64'(m_stb0));
        chk("dout0", 64'(dout0), 64'(m_out0));
        chk("occ0", 64'(occ0), 64'(m_occ));
        chk("err0", 64'(err0), 64'(m_err));
        chk("stb1", 64'(stbo1), 64'(m_stb1));
        chk("dout1", 64'(dout1), 64'(m_out1));
        chk("err1", 64'(err1), 64'(m_err));
    endtask

    function automatic logic [NC*W-1:0] mk(input int n);
        logic [NC*W-1:0] v;
        for (int c = 0; c < NC; c++) v[c*W +: W] = 8'(n * 4 + c);
        return v;
    endfunction

    function automatic logic [NC*DW-1:0] pk(input int d0, input int d1, input int d2, input int d3);
        return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
    endfunction

    task automatic model_reset();
        hist.delete();
        sb.delete();
        m_out0 = {NC{DEF}};
        m_out1 = {NC{DEF}};
        m_stb0 = 1'b0;
        m_stb1 = 1'b0;
        m_err  = 1'b0;
        m_occ  = 0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        clk_en = 1'b1;
        stb_in = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
        model_reset();
        check_all();
        reset = 1'b0;
        stb_in = 1'b0;
    endtask

    task automatic step(input logic en, input logic stb, input logic fl,
                        input logic [NC*W-1:0] din, input logic [NC*DW-1:0] dly);
        logic acc;
        logic [NC*W-1:0] e;
        int d;
        clk_en = en; stb_in = stb; flush = fl; data_in = din; delay = dly;
        acc = en & stb;
        if (en && fl) begin
            hist.delete();
            m_occ = 0;
        end
        if (acc) begin
            hist.push_back(din);
            if (hist.size() > D) void'(hist.pop_front());
            if (m_occ < D) m_occ++;
            for (int c = 0; c < NC; c++) begin
                d = int'(dly[c*DW +: DW]);
                e[c*W +: W] = DEF;
                if (d > D - 1) begin
                    m_err = 1'b1;
`ifdef VARIABLE_DELAY_LINE_MC_DELAY_CLAMP_EN
                    d = D - 1;
`else
                    d = D;
`endif
                end
                if (d < m_occ) e[c*W +: W] = hist[hist.size() - 1 - d][c*W +: W];
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (en) begin
            if (m_stb0) m_out1 = m_out0;
            m_stb1 = m_stb0;
            m_stb0 = acc;
            if (acc) m_out0 = sb.pop_front();
        end
        check_all();
    endtask

    initial begin
        model_reset();
        do_reset(2);

        // dense ramp, wrap across 5 -> 0, occupancy saturation
        for (int n = 0; n < 20; n++) step(1, 1, 0, mk(n), pk(0, 1, 2, 5));
        // idle: outputs hold
        step(1, 0, 0, mk(200), pk(0, 1, 2, 5));
        step(1, 0, 0, mk(201), pk(0, 1, 2, 5));

        // sparse strobes with a clk_en hole
        for (int i = 0; i < 18; i++)
            step(!(i >= 7 && i <= 10), (i % 3) == 0, 0, mk(20 + i), pk(2, 2, 3, 4));

        // delay change, no glitch on other lanes
        for (int i = 0; i < 4; i++) step(1, 1, 0, mk(60 + i), pk(1, 0, 5, 3));

        // flush with simultaneous sample, then the next one
        step(1, 1, 1, {NC{8'd99}}, pk(1, 1, 1, 1));
        step(1, 1, 0, {NC{8'd100}}, pk(1, 1, 1, 1));
        step(1, 0, 1, mk(70), pk(1, 1, 1, 1));
        step(0, 1, 1, mk(71), pk(0, 0, 1, 0));
        step(1, 1, 0, mk(72), pk(0, 0, 1, 0));
        step(1, 1, 0, mk(73), pk(0, 1, 1, 0));

        // out-of-range taps on lanes 2 and 3
        for (int i = 0; i < 8; i++) step(1, 1, 0, mk(40 + i), pk(1, 0, 7, 6));
        step(1, 1, 0, mk(48), pk(1, 1, 1, 1));
        step(1, 0, 0, mk(49), pk(1, 1, 1, 1));

        // randomized traffic
        for (int i = 0; i < 80; i++)
            step(($urandom % 5) != 0, ($urandom % 3) != 0, ($urandom % 12) == 0,
                 NC*W'($urandom), NC*DW'($urandom));

        // reset with two strobes in flight
        step(1, 1, 0, mk(80), pk(0, 1, 2, 3));
        step(1, 1, 0, mk(81), pk(0, 1, 2, 3));
        do_reset(1);
        step(1, 1, 0, mk(7), pk(3, 3, 3, 3));
        for (int i = 0; i < 5; i++) step(1, 1, 0, mk(8 + i), pk(3, 0, 2, 1));
        step(1, 0, 0, mk(0), pk(0, 0, 0, 0));
        step(1, 0, 0, mk(0), pk(0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
